// File: rtl/render_pkg.sv
// Shared types and constants for the render pixel packer.
package render_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_PIXEL_WIDTH = 24;
    localparam int DEF_LEN_W       = 12;

    // Byte-enable bits needed to cover one pixel.
    function automatic int keep_w(input int pixel_width);
        return pixel_width / 8;
    endfunction

endpackage

// File: rtl/render_geom_counter.sv
// Pixel/line position tracker; geometry is latched when a frame starts.
module render_geom_counter
    import render_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             i_start,
    input  logic             i_advance,
    input  logic [LEN_W-1:0] i_line_len,
    input  logic [LEN_W-1:0] i_frame_lines,
    output logic             o_last_in_line,
    output logic             o_last_in_frame
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_lines;
    logic [LEN_W-1:0] r_pix;
    logic [LEN_W-1:0] r_line;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len   <= '0;
            r_lines <= '0;
            r_pix   <= '0;
            r_line  <= '0;
        end else if (i_start) begin
            r_len   <= i_line_len;
            r_lines <= i_frame_lines;
            r_pix   <= '0;
            r_line  <= '0;
        end else if (i_advance) begin
            if (o_last_in_line) begin
                r_pix  <= '0;
                r_line <= r_line + ONE;
            end else begin
                r_pix <= r_pix + ONE;
            end
        end
    end

    assign o_last_in_line  = (r_pix == r_len - ONE);
    assign o_last_in_frame = o_last_in_line && (r_line == r_lines - ONE);

endmodule

// File: rtl/render_pixel_packer.sv
// Packs OUT_PIXELS pixels per AXI4-Stream video beat with SOF/EOL framing and frame-end checks.
// Optional statistics counters are enabled with `define RENDER_PACK_STATS_EN.
module render_pixel_packer
    import render_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int OUT_PIXELS  = 2,
    parameter int LEN_W       = DEF_LEN_W
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                enable,
    input  logic [LEN_W-1:0]                    line_len,
    input  logic [LEN_W-1:0]                    frame_lines,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic [PIXEL_WIDTH-1:0]              s_tdata,
    input  logic                                s_tlast,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [PIXEL_WIDTH*OUT_PIXELS-1:0]   m_tdata,
    output logic [PIXEL_WIDTH*OUT_PIXELS/8-1:0] m_tkeep,
    output logic                                m_tuser,
    output logic                                m_tlast,
    output logic                                busy,
    output logic                                err_early,
    output logic                                err_late,
    input  logic                                err_clr
`ifdef RENDER_PACK_STATS_EN
    ,
    output logic [31:0]                         frame_count,
    output logic [31:0]                         stall_count
`endif
);

    localparam int KEEP_W = keep_w(PIXEL_WIDTH);
    localparam int BEAT_W = PIXEL_WIDTH * OUT_PIXELS;
    localparam int BKEEP_W = KEEP_W * OUT_PIXELS;
    localparam int LANE_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

    state_t              r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [BEAT_W-1:0]   r_acc;
    logic                r_first;
    logic                r_m_tvalid;
    logic [BEAT_W-1:0]   r_m_tdata;
    logic [BKEEP_W-1:0]  r_m_tkeep;
    logic                r_m_tuser;
    logic                r_m_tlast;
    logic                r_err_early;
    logic                r_err_late;

    logic                w_start;
    logic                w_accept;
    logic                w_last_line;
    logic                w_last_frame;
    logic                w_lane_full;
    logic                w_beat_done;
    logic                w_early;
    logic                w_late;
    logic [BEAT_W-1:0]   w_beat_data;
    logic [BKEEP_W-1:0]  w_beat_keep;

    assign w_start  = (r_state == IDLE) && enable && (line_len != '0) && (frame_lines != '0);
    assign s_tready = (r_state == RUN) && (!r_m_tvalid || m_tready);
    assign w_accept = s_tvalid && s_tready;

    render_geom_counter #(
        .LEN_W (LEN_W)
    ) u_geom (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .i_start         (w_start),
        .i_advance       (w_accept),
        .i_line_len      (line_len),
        .i_frame_lines   (frame_lines),
        .o_last_in_line  (w_last_line),
        .o_last_in_frame (w_last_frame)
    );

    assign w_lane_full = (int'(r_lane) == OUT_PIXELS - 1);
    // s_tlast on any pixel closes the current beat, so an early end-of-frame flushes cleanly.
    assign w_beat_done = w_accept && (w_lane_full || w_last_line || s_tlast);
    assign w_early     = w_accept && s_tlast && !w_last_frame;
    assign w_late      = w_accept && w_last_frame && !s_tlast;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_beat_data = '0;
        w_beat_keep = '0;
        for (int i = 0; i < OUT_PIXELS; i++) begin
            if (i < int'(r_lane)) begin
                w_beat_data[i*PIXEL_WIDTH +: PIXEL_WIDTH] = r_acc[i*PIXEL_WIDTH +: PIXEL_WIDTH];
                w_beat_keep[i*KEEP_W +: KEEP_W]           = '1;
            end else if (i == int'(r_lane)) begin
                w_beat_data[i*PIXEL_WIDTH +: PIXEL_WIDTH] = s_tdata;
                w_beat_keep[i*KEEP_W +: KEEP_W]           = '1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= IDLE;
            r_lane      <= '0;
            r_acc       <= '0;
            r_first     <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tuser   <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_first <= 1'b1;
                        r_lane  <= '0;
                        r_acc   <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_beat_done) begin
                            r_lane <= '0;
                            r_acc  <= '0;
                        end else begin
                            r_acc[int'(r_lane)*PIXEL_WIDTH +: PIXEL_WIDTH] <= s_tdata;
                            r_lane <= r_lane + LANE_W'(1);
                        end
                        if (w_last_frame || s_tlast) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_m_tvalid && m_tready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // s_tready guarantees the output register is free whenever a beat completes.
            if (w_beat_done) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_beat_data;
                r_m_tkeep  <= w_beat_keep;
                r_m_tuser  <= r_first;
                r_m_tlast  <= w_last_line || s_tlast;
                r_first    <= 1'b0;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_early) begin
                r_err_early <= 1'b1;
            end else if (err_clr) begin
                r_err_early <= 1'b0;
            end
            if (w_late) begin
                r_err_late <= 1'b1;
            end else if (err_clr) begin
                r_err_late <= 1'b0;
            end
        end
    end

    assign m_tvalid  = r_m_tvalid;
    assign m_tdata   = r_m_tdata;
    assign m_tkeep   = r_m_tkeep;
    assign m_tuser   = r_m_tuser;
    assign m_tlast   = r_m_tlast;
    assign busy      = (r_state != IDLE);
    assign err_early = r_err_early;
    assign err_late  = r_err_late;

`ifdef RENDER_PACK_STATS_EN
    logic [31:0] r_frame_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_frame_count <= '0;
            r_stall_count <= '0;
        end else if (err_clr) begin
            r_frame_count <= '0;
            r_stall_count <= '0;
        end else begin
            if ((r_state == DRAIN) && r_m_tvalid && m_tready) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (r_m_tvalid && !m_tready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_render_pixel_packer.sv
// Randomised self-checking bench for render_pixel_packer against a frame-level beat model.
module tb_render_pixel_packer;

    localparam int PW = 24;
    localparam int OP = 2;
    localparam int LW = 12;
    localparam int BW = PW * OP;
    localparam int KW = PW / 8;
    localparam int KB = KW * OP;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [KB-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          enable;
    logic [LW-1:0] line_len;
    logic [LW-1:0] frame_lines;
    logic          s_tvalid;
    logic          s_tready;
    logic [PW-1:0] s_tdata;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [BW-1:0] m_tdata;
    logic [KB-1:0] m_tkeep;
    logic          m_tuser;
    logic          m_tlast;
    logic          busy;
    logic          err_early;
    logic          err_late;
    logic          err_clr;

    render_pixel_packer #(
        .PIXEL_WIDTH (PW),
        .OUT_PIXELS  (OP),
        .LEN_W       (LW)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .enable      (enable),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .err_early   (err_early),
        .err_late    (err_late),
        .err_clr     (err_clr)
    );

    int      n_vec  = 0;
    int      n_miss = 0;
    beat_t   exp_q[$];
    beat_t   got_q[$];
    logic [PW-1:0] pix_mem [0:63];
    bit      exp_early;
    bit      exp_late;
    int      n_send;
    bit      rdy_hold = 1'b0;
    bit      rdy_rand = 1'b0;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge ap_clk) begin
        #1;
        if (rdy_hold)      m_tready = 1'b0;
        else if (rdy_rand) m_tready = ($urandom_range(0, 3) != 0);
        else               m_tready = 1'b1;
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n && m_tvalid && m_tready) begin
            beat_t b;
            b.data = m_tdata;
            b.keep = m_tkeep;
            b.user = m_tuser;
            b.last = m_tlast;
            got_q.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: split the delivered pixels into lines, chunk each line into beats.
    task automatic build_expected(input int len, input int lines, input int tidx);
        int    total;
        int    last;
        bit    first;
        beat_t b;
        total     = len * lines;
        first     = 1'b1;
        exp_q.delete();
        exp_early = (tidx >= 0) && (tidx < total - 1);
        exp_late  = !exp_early && (tidx != total - 1);
        last      = exp_early ? tidx : total - 1;
        n_send    = last + 1;
        for (int l = 0; l * len <= last; l++) begin
            int lo = l * len;
            int hi = (lo + len - 1 < last) ? lo + len - 1 : last;
            for (int g = lo; g <= hi; g += OP) begin
                b = '0;
                for (int j = 0; j < OP && g + j <= hi; j++) begin
                    b.data[j*PW +: PW] = pix_mem[g+j];
                    b.keep[j*KW +: KW] = '1;
                end
                b.user = first;
                b.last = (g + OP > hi);
                first  = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drive_pix(input logic [PW-1:0] d, input bit last, output bit ok);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        ok       = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ap_clk);
            if (s_tready) begin
                ok = 1'b1;
                @(posedge ap_clk);
                #1;
                break;
            end
            @(posedge ap_clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!ok) check("px_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_frame(input int len, input int lines, output bit ok);
        ok          = 1'b0;
        line_len    = LW'(len);
        frame_lines = LW'(lines);
        enable      = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ap_clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge ap_clk);
            #1;
        end
        @(posedge ap_clk);
        #1;
        enable      = 1'b0;
        line_len    = LW'($urandom_range(1, 9));
        frame_lines = LW'($urandom_range(1, 9));
        if (!ok) check("start_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input int len, input int lines, input int tidx, input bit gaps);
        bit ok;
        int n;
        got_q.delete();
        build_expected(len, lines, tidx);
        start_frame(len, lines, ok);
        for (int k = 0; k < n_send && ok; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge ap_clk);
                #1;
            end
            drive_pix(pix_mem[k], (k == tidx), ok);
        end
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge ap_clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy_idle", {63'd0, busy}, 64'd0);
        @(posedge ap_clk);
        #1;
        check("beat_cnt", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("b%0d_data", i), 64'(got_q[i].data), 64'(exp_q[i].data));
            check($sformatf("b%0d_keep", i), 64'(got_q[i].keep), 64'(exp_q[i].keep));
            check($sformatf("b%0d_user", i), 64'(got_q[i].user), 64'(exp_q[i].user));
            check($sformatf("b%0d_last", i), 64'(got_q[i].last), 64'(exp_q[i].last));
        end
        check("err_early", {63'd0, err_early}, {63'd0, exp_early});
        check("err_late",  {63'd0, err_late},  {63'd0, exp_late});
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        @(negedge ap_clk);
        check("clr_early", {63'd0, err_early}, 64'd0);
        check("clr_late",  {63'd0, err_late},  64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic stall_seq();
        bit seen;
        logic [BW-1:0] d0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge ap_clk);
            if (m_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        rdy_hold = 1'b1;
        @(posedge ap_clk);
        #1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            if (m_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_valid_seen", {63'd0, seen}, 64'd1);
        d0 = m_tdata;
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            check("stall_s_tready", {63'd0, s_tready}, 64'd0);
            check("stall_m_tvalid", {63'd0, m_tvalid}, 64'd1);
            check("stall_m_tdata",  64'(m_tdata), 64'(d0));
        end
        rdy_hold = 1'b0;
    endtask

    initial begin
        bit ok;
        ap_rst_n    = 1'b0;
        enable      = 1'b0;
        line_len    = '0;
        frame_lines = '0;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tlast     = 1'b0;
        m_tready    = 1'b0;
        err_clr     = 1'b0;
        #22;
        check("rst_m_tvalid",  {63'd0, m_tvalid},  64'd0);
        check("rst_m_tdata",   64'(m_tdata),       64'd0);
        check("rst_m_tkeep",   64'(m_tkeep),       64'd0);
        check("rst_m_tuser",   {63'd0, m_tuser},   64'd0);
        check("rst_m_tlast",   {63'd0, m_tlast},   64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_s_tready",  {63'd0, s_tready},  64'd0);
        check("rst_err_early", {63'd0, err_early}, 64'd0);
        check("rst_err_late",  {63'd0, err_late},  64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Zero geometry must keep the block idle.
        line_len    = 12'd0;
        frame_lines = 12'd2;
        enable      = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("zero_len_idle", {63'd0, busy}, 64'd0);
        line_len    = 12'd4;
        frame_lines = 12'd0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("zero_lines_idle", {63'd0, busy}, 64'd0);
        enable = 1'b0;

        // Basic packing, 4x2.
        for (int k = 0; k < 8; k++) pix_mem[k] = PW'(k + 1);
        run_frame(4, 2, 7, 1'b0);

        // Partial beat at end of a 3-pixel line.
        pix_mem[0] = 24'hA1A2A3;
        pix_mem[1] = 24'hB1B2B3;
        pix_mem[2] = 24'hC1C2C3;
        run_frame(3, 1, 2, 1'b0);

        // Backpressure for 10 cycles mid-frame.
        for (int k = 0; k < 16; k++) pix_mem[k] = PW'($urandom);
        fork
            run_frame(8, 2, 15, 1'b0);
            stall_seq();
        join

        // Early TLAST on pixel 5.
        for (int k = 0; k < 8; k++) pix_mem[k] = PW'($urandom);
        run_frame(4, 2, 4, 1'b0);

        // Late TLAST, then a following frame must carry SOF again.
        for (int k = 0; k < 4; k++) pix_mem[k] = PW'($urandom);
        run_frame(2, 2, -1, 1'b0);
        for (int k = 0; k < 3; k++) pix_mem[k] = PW'($urandom);
        run_frame(3, 1, 2, 1'b0);

        // Randomised frames with random gaps, backpressure and end-of-frame behaviour.
        rdy_rand = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int len;
            int lines;
            int total;
            int tidx;
            int mode;
            len   = $urandom_range(1, 7);
            lines = $urandom_range(1, 4);
            total = len * lines;
            mode  = $urandom_range(0, 2);
            for (int k = 0; k < total; k++) pix_mem[k] = PW'($urandom);
            if (mode == 0)      tidx = total - 1;
            else if (mode == 1) tidx = -1;
            else                tidx = $urandom_range(0, total - 1);
            run_frame(len, lines, tidx, 1'b1);
        end
        rdy_rand = 1'b0;

        // Reset mid-frame after three pixels, while a beat is pending.
        for (int k = 0; k < 3; k++) pix_mem[k] = PW'($urandom);
        start_frame(3, 2, ok);
        for (int k = 0; k < 3 && ok; k++) drive_pix(pix_mem[k], 1'b0, ok);
        check("pre_rst_valid", {63'd0, m_tvalid}, 64'd1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("async_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("async_m_tdata",  64'(m_tdata),      64'd0);
        check("async_busy",     {63'd0, busy},     64'd0);
        check("async_m_tlast",  {63'd0, m_tlast},  64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        for (int k = 0; k < 6; k++) pix_mem[k] = PW'($urandom);
        run_frame(3, 2, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/render_pixel_packer.md
Name: render_pixel_packer

Overview:
- Output stage between the rasteriser core's 24-bit pixel stream and the video DMA / VDMA write port.
- Packs OUT_PIXELS pixels per output beat.
- Generates AXI4-Stream video framing: TUSER marks start-of-frame, TLAST marks end-of-line.
- Checks the core's end-of-frame TLAST against the programmed frame geometry; line_len and frame_lines come from the AXI-lite register bank.

Parameters:
- PIXEL_WIDTH, 24, bits per pixel; must be a multiple of 8.
- OUT_PIXELS, 2, pixels per output beat; must be ≥1.
- LEN_W, 12, width of the line-length and line-count fields.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; allows a new frame to start.
- line_len  in  LEN_W  pixels per line.
- frame_lines  in  LEN_W  lines per frame.
- s_tvalid  in  1  input pixel valid.
- s_tready  out  1  input pixel ready.
- s_tdata  in  PIXEL_WIDTH  pixel.
- s_tlast  in  1  core end-of-frame marker.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  output beat ready.
- m_tdata  out  PIXEL_WIDTH*OUT_PIXELS  packed pixels; lane 0 in the LSBs.
- m_tkeep  out  PIXEL_WIDTH*OUT_PIXELS/8  byte enables.
- m_tuser  out  1  start-of-frame, on the first beat of a frame.
- m_tlast  out  1  end-of-line.
- busy  out  1  high in RUN and DRAIN.
- err_early  out  1  sticky: s_tlast arrived before the frame's last pixel.
- err_late  out  1  sticky: frame's last pixel arrived without s_tlast.
- err_clr  in  1  one-cycle pulse; clears both error flags.

Behaviour:
- Clock and reset: one clock, ap_clk. ap_rst_n is asynchronous and active-low.
- Reset values: all outputs 0. State IDLE; lane, pixel and line counters 0; accumulator 0.
- State machine:
  - IDLE → RUN when enable=1, line_len≠0 and frame_lines≠0. line_len and frame_lines are latched on this transition; later changes are ignored until the next frame.
  - If either value is 0, stay in IDLE.
  - RUN → DRAIN when the frame's last pixel is accepted, or when s_tlast is accepted.
  - DRAIN → IDLE when the final beat handshakes (m_tvalid & m_tready).
- s_tready = (state==RUN) & (!m_tvalid | m_tready). A combinational path from m_tready is permitted.
- Packing:
  - Accepted pixel goes to lane `lane` of the accumulator; lane then increments.
  - A beat is complete when lane reaches OUT_PIXELS-1, or when the pixel is the last of its line.
  - On completion, accumulator plus the accepting pixel go to the output register the same edge. m_tvalid rises the next cycle, so latency is 1 cycle from the completing pixel's handshake.
  - lane resets to 0 after completion.
- Partial beat at end of line: unused lanes carry data 0 and keep 0. A new line always starts in lane 0.
- m_tkeep: PIXEL_WIDTH/8 bits per lane; all-ones for filled lanes.
- m_tuser=1 only on the first beat after IDLE→RUN. m_tlast=1 on the beat containing pixel line_len-1 of each line.
- Output register holds data stable while m_tvalid & !m_tready.
- Counters: the pixel counter wraps to 0 at line_len-1 and increments the line counter. The frame's last pixel is line==frame_lines-1 and pixel==line_len-1.
- Frame-end checks:
  - s_tlast on a non-final pixel: set err_early, emit that pixel's beat with m_tlast=1 (flush), go to DRAIN. Remaining geometry is abandoned.
  - Final pixel without s_tlast: set err_late, end the frame normally.
  - s_tlast exactly on the final pixel: no error.
- Error clearing: err_clr in the same cycle as a new error event leaves the flag set (set wins).
- Throughput: 1 pixel/cycle while m_tready=1.
- enable deasserted mid-frame has no effect; the frame completes.
- Reset mid-frame discards all partial data immediately.

Optional Feature:
- Macro: RENDER_PACK_STATS_EN.
- When defined: adds outputs frame_count[31:0] (increments on each DRAIN→IDLE) and stall_count[31:0] (increments each cycle m_tvalid & !m_tready). Both reset to 0, clear on err_clr, and wrap at 2^32.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package render_pkg:
  - state enum (IDLE/RUN/DRAIN);
  - default PIXEL_WIDTH and LEN_W constants;
  - KEEP_W = PIXEL_WIDTH/8 helper.
- One natural sub-module, render_geom_counter: pixel/line counters with latched geometry, providing last_in_line and last_in_frame flags.

Test Plan:
- Basic packing: line_len=4, frame_lines=2, OUT_PIXELS=2, pixels 0x000001..0x000008, s_tlast on the 8th pixel.
  - Expect 4 beats; beat0 m_tdata=0x000002000001, m_tuser=1.
  - m_tlast on beats 1 and 3; errors stay 0; busy returns to 0.
- Partial-beat flush: line_len=3, frame_lines=1, pixels A,B,C, s_tlast on C.
  - Expect beat {B,A} with keep=0x3F, then beat {0,C} with keep=0x07 and m_tlast=1.
- Backpressure: m_tready held 0 for 10 cycles mid-frame.
  - Expect s_tready=0 and m_tdata stable.
  - After release, all pixels arrive in order with none lost.
- Early TLAST: line_len=4, frame_lines=2, s_tlast on pixel 5.
  - Expect err_early=1 and a flushed beat with m_tlast=1; state returns to IDLE.
  - err_clr pulse then returns err_early to 0.
- Late TLAST: geometry 2×2, no s_tlast.
  - Expect err_late=1 after pixel 4; next frame starts with m_tuser=1.
- Mid-frame reset: assert ap_rst_n=0 after 3 pixels.
  - Outputs go to 0 immediately (asynchronously).
  - After release, a fresh frame packs from lane 0 with m_tuser=1.
